// File: rtl/i2s_sample_feeder.sv
// Stereo sample FIFO feeding the I2S transmitter: one L/R pair is popped at each
// falling edge of frame_clk (start of the left word) and held for the whole frame.
module i2s_sample_feeder #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned DEPTH         = 8,
  parameter bit          UNDERRUN_ZERO = 1'b1,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LVL_W = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              frame_clk,
  output logic [DATA_W-1:0] send_queue_left,
  output logic [DATA_W-1:0] send_queue_right,
  output logic [LVL_W-1:0]  level,
  output logic              underrun,
  output logic [15:0]       underrun_count
);

  localparam int unsigned PAIR_W = 2 * DATA_W;

  logic [PAIR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic              underrun_q, underrun_d;
  logic [15:0]       ucount_q, ucount_d;
  logic              fc_q;
  logic              boundary, push, pop;

  assign in_ready = (level_q != LVL_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign boundary = fc_q && !frame_clk;
  assign pop      = boundary && (level_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    left_d     = left_q;
    right_d    = right_q;
    underrun_d = 1'b0;
    ucount_d   = ucount_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      {left_d, right_d} = mem_q[rd_ptr_q];
    end else if (boundary) begin
      // Empty FIFO at a frame start: flag it and optionally mute the output.
      underrun_d = 1'b1;
      if (ucount_q != 16'hFFFF) ucount_d = ucount_q + 16'd1;
      if (UNDERRUN_ZERO) begin
        left_d  = '0;
        right_d = '0;
      end
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      left_q     <= '0;
      right_q    <= '0;
      underrun_q <= 1'b0;
      ucount_q   <= '0;
      fc_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      left_q     <= left_d;
      right_q    <= right_d;
      underrun_q <= underrun_d;
      ucount_q   <= ucount_d;
      fc_q       <= frame_clk;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_left, in_right};
  end

  assign send_queue_left  = left_q;
  assign send_queue_right = right_q;
  assign level            = level_q;
  assign underrun         = underrun_q;
  assign underrun_count   = ucount_q;

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Directed bench for i2s_sample_feeder; a second instance with UNDERRUN_ZERO=0
// shares the stimulus to check the hold-on-underrun behaviour.
module tb_i2s_sample_feeder;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset, in_valid, frame_clk;
  logic [DATA_W-1:0] in_left, in_right;

  logic              in_ready, underrun;
  logic [DATA_W-1:0] sq_left, sq_right;
  logic [LVL_W-1:0]  level;
  logic [15:0]       ucount;

  logic              h_in_ready, h_underrun;
  logic [DATA_W-1:0] h_sq_left, h_sq_right;
  logic [LVL_W-1:0]  h_level;
  logic [15:0]       h_ucount;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i2s_sample_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .UNDERRUN_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .frame_clk(frame_clk),
    .send_queue_left(sq_left), .send_queue_right(sq_right),
    .level(level), .underrun(underrun), .underrun_count(ucount)
  );

  i2s_sample_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .UNDERRUN_ZERO(1'b0)) dut_h (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(h_in_ready),
    .in_left(in_left), .in_right(in_right), .frame_clk(frame_clk),
    .send_queue_left(h_sq_left), .send_queue_right(h_sq_right),
    .level(h_level), .underrun(h_underrun), .underrun_count(h_ucount)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    in_valid = 1'b1; in_left = l; in_right = r;
    tick();
    in_valid = 1'b0;
  endtask

  // One-cycle low on frame_clk; checks the registered results of that boundary.
  task automatic boundary_check(input string tag, input logic [DATA_W-1:0] el,
                                input logic [DATA_W-1:0] er, input logic eu,
                                input logic [LVL_W-1:0] elvl);
    frame_clk = 1'b0;
    tick();
    check_eq({tag, "_pair"}, {sq_left, sq_right}, {el, er});
    check_eq({tag, "_underrun"}, 32'(underrun), 32'(eu));
    check_eq({tag, "_level"}, 32'(level), 32'(elvl));
    frame_clk = 1'b1;
    tick();
    check_eq({tag, "_underrun_clr"}, 32'(underrun), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; frame_clk = 1'b1; in_left = '0; in_right = '0;
    tick(); tick();
    reset = 1'b0;
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_pair", {sq_left, sq_right}, 32'd0);
    check_eq("rst_underrun", 32'(underrun), 32'd0);
    check_eq("rst_count", 32'(ucount), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    tick();
    check_eq("rst_no_boundary", 32'(underrun), 32'd0);

    // 1: single pair through one boundary
    push_pair(16'd7, 16'd13);
    check_eq("t1_level", 32'(level), 32'd1);
    boundary_check("t1", 16'd7, 16'd13, 1'b0, LVL_W'(0));

    // 2: fill to DEPTH, reject a ninth pair, pop four in order
    for (int i = 1; i <= 8; i++) push_pair(DATA_W'(i), DATA_W'(i + 1));
    check_eq("t2_full_level", 32'(level), 32'd8);
    check_eq("t2_full_ready", 32'(in_ready), 32'd0);
    push_pair(16'd99, 16'd98);
    check_eq("t2_reject_level", 32'(level), 32'd8);
    for (int i = 1; i <= 4; i++)
      boundary_check($sformatf("t2_pop%0d", i), DATA_W'(i), DATA_W'(i + 1), 1'b0, LVL_W'(8 - i));
    boundary_check("t2_pop5", 16'd5, 16'd6, 1'b0, LVL_W'(3));

    // 4: push and boundary in the same cycle at level 3
    in_valid = 1'b1; in_left = 16'd20; in_right = 16'd21; frame_clk = 1'b0;
    tick();
    in_valid = 1'b0; frame_clk = 1'b1;
    check_eq("t4_level", 32'(level), 32'd3);
    check_eq("t4_pair", {sq_left, sq_right}, {16'd6, 16'd7});
    tick();
    boundary_check("t4_d1", 16'd7, 16'd8, 1'b0, LVL_W'(2));
    boundary_check("t4_d2", 16'd8, 16'd9, 1'b0, LVL_W'(1));
    boundary_check("t4_tail", 16'd20, 16'd21, 1'b0, LVL_W'(0));

    // 3: two underruns on an empty FIFO
    boundary_check("t3_u1", 16'd0, 16'd0, 1'b1, LVL_W'(0));
    check_eq("t3_hold_pair", {h_sq_left, h_sq_right}, {16'd20, 16'd21});
    boundary_check("t3_u2", 16'd0, 16'd0, 1'b1, LVL_W'(0));
    check_eq("t3_count", 32'(ucount), 32'd2);
    check_eq("t3_hold_count", 32'(h_ucount), 32'd2);
    check_eq("t3_hold_pair2", {h_sq_left, h_sq_right}, {16'd20, 16'd21});

    // Push into empty FIFO on a boundary: underrun, no bypass
    in_valid = 1'b1; in_left = 16'd30; in_right = 16'd31; frame_clk = 1'b0;
    tick();
    in_valid = 1'b0; frame_clk = 1'b1;
    check_eq("nb_underrun", 32'(underrun), 32'd1);
    check_eq("nb_pair", {sq_left, sq_right}, 32'd0);
    check_eq("nb_level", 32'(level), 32'd1);
    check_eq("nb_count", 32'(ucount), 32'd3);
    tick();
    boundary_check("nb_next", 16'd30, 16'd31, 1'b0, LVL_W'(0));

    // 5: reset mid-frame with level 5
    for (int i = 0; i < 5; i++) push_pair(DATA_W'(40 + i), DATA_W'(50 + i));
    check_eq("t5_level_pre", 32'(level), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t5_level", 32'(level), 32'd0);
    check_eq("t5_pair", {sq_left, sq_right}, 32'd0);
    check_eq("t5_count", 32'(ucount), 32'd0);
    check_eq("t5_ready", 32'(in_ready), 32'd1);
    boundary_check("t5_u", 16'd0, 16'd0, 1'b1, LVL_W'(0));
    check_eq("t5_count_after", 32'(ucount), 32'd1);

    // 6: saturation; preload the counter close to the top instead of 65k frames
    force dut.ucount_q = 16'hFFFE;
    tick();
    release dut.ucount_q;
    tick();
    check_eq("t6_preload", 32'(ucount), 32'h0000FFFE);
    boundary_check("t6_b1", 16'd0, 16'd0, 1'b1, LVL_W'(0));
    check_eq("t6_count_max", 32'(ucount), 32'h0000FFFF);
    boundary_check("t6_b2", 16'd0, 16'd0, 1'b1, LVL_W'(0));
    check_eq("t6_count_sat", 32'(ucount), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
